// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display scheduler.
//   disp_state_t : page FSM encoding
//   SEG_BLANK    : all segments off (active-low)
//   AN_OFF       : all anodes off (active-low)
//   HEX_SEG      : hex digit 0..F -> {g,f,e,d,c,b,a}, active-low
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW_LO = 2'd1,
        SHOW_HI = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/display_scheduler_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to 7-segment decoder.
//   nibble : 4-bit value to show
//   seg    : active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: time-shares a 4-digit 7-segment display between
// NUM_SRC 32-bit debug sources, two 16-bit pages per source (low, then high).
// Pages advance on a dwell timer or a debounced push-button step.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   src_data     : NUM_SRC packed 32-bit values, source i at [32*i+31:32*i]
//   src_valid    : per-source display request
//   btn_next     : raw asynchronous push-button, step to next page
//   hold         : freeze the dwell timer
//   seg, an      : active-low segments {g,f,e,d,c,b,a} and digit anodes
//   cur_src      : index of the source shown
//   cur_half     : 0 = bits [15:0], 1 = bits [31:16]
//   dp           : active-low decimal point (only with DISP_DP_INDICATOR_EN)
//
// Build option: define DISP_DP_INDICATOR_EN to add the dp output, lit on the
// leftmost digit while the high half is shown.
//
// state   | meaning
// IDLE    | no source valid, display blank
// SHOW_LO | showing bits [15:0] of cur_src
// SHOW_HI | showing bits [31:16] of cur_src
module display_scheduler
    import disp_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int DWELL_CYCLES    = 100000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_BITS       = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC*32-1:0]      src_data,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic                       btn_next,
    input  logic                       hold,
    output logic [6:0]                 seg,
    output logic [3:0]                 an,
`ifdef DISP_DP_INDICATOR_EN
    output logic                       dp,
`endif
    output logic [$clog2(NUM_SRC)-1:0] cur_src,
    output logic                       cur_half
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    disp_state_t          state, state_nxt;
    logic [SRC_W-1:0]     src_nxt;
    logic                 half_nxt;
    logic                 page_load;
    logic [DW_W-1:0]      dwell_cnt;
    logic                 dwell_expire;
    logic                 btn_s1, btn_s2, db_level, db_prev;
    logic [DB_W-1:0]      db_cnt;
    logic                 step;
    logic                 advance;
    logic [15:0]          half_words [2*NUM_SRC];
    logic [15:0]          snapshot;
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [1:0]           sel;
    logic [3:0]           an_q;
    logic [3:0]           nib_q;
    logic [6:0]           seg_dec;

    // First valid source at or after 'start', wrapping; lowest offset wins.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] v,
                                                  input int start);
        logic [SRC_W-1:0] pick;
        int idx;
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (start + i) % NUM_SRC;
            if (v[idx[SRC_W-1:0]]) pick = idx[SRC_W-1:0];
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < 2*NUM_SRC; i++) half_words[i] = src_data[16*i +: 16];
    end

    // Button: 2-flop synchronizer, then level accepted after it differs
    // for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_s1  <= btn_next;
            btn_s2  <= btn_s1;
            db_prev <= db_level;
            if (btn_s2 != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= btn_s2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign step         = db_level & ~db_prev;
    assign dwell_expire = (state != IDLE) && !hold && (dwell_cnt == DW_W'(DWELL_CYCLES - 1));
    // Expiry and step in the same cycle collapse into one advance.
    assign advance      = dwell_expire | step;

    always_comb begin
        state_nxt = state;
        src_nxt   = cur_src;
        half_nxt  = cur_half;
        page_load = 1'b0;
        case (state)
            IDLE: begin
                if (|src_valid) begin
                    state_nxt = SHOW_LO;
                    src_nxt   = rr_pick(src_valid, 0);
                    half_nxt  = 1'b0;
                    page_load = 1'b1;
                end
            end
            SHOW_LO, SHOW_HI: begin
                if (!src_valid[cur_src]) begin
                    page_load = 1'b1;
                    if (|src_valid) begin
                        state_nxt = SHOW_LO;
                        src_nxt   = rr_pick(src_valid, int'(cur_src) + 1);
                        half_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (advance) begin
                    page_load = 1'b1;
                    if (state == SHOW_LO) begin
                        state_nxt = SHOW_HI;
                        half_nxt  = 1'b1;
                    end else begin
                        state_nxt = SHOW_LO;
                        half_nxt  = 1'b0;
                        src_nxt   = rr_pick(src_valid, int'(cur_src) + 1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_src   <= '0;
            cur_half  <= 1'b0;
            dwell_cnt <= '0;
            snapshot  <= '0;
        end else begin
            state    <= state_nxt;
            cur_src  <= src_nxt;
            cur_half <= half_nxt;
            if (state == IDLE || page_load) begin
                dwell_cnt <= '0;
            end else if (!hold) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            if (page_load) snapshot <= half_words[{src_nxt, half_nxt}];
        end
    end

    assign sel = scan_cnt[SCAN_BITS-1 -: 2];

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            an_q     <= AN_OFF;
            nib_q    <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            case (sel)
                2'd0:    begin an_q <= 4'b1110; nib_q <= snapshot[3:0];   end
                2'd1:    begin an_q <= 4'b1101; nib_q <= snapshot[7:4];   end
                2'd2:    begin an_q <= 4'b1011; nib_q <= snapshot[11:8];  end
                default: begin an_q <= 4'b0111; nib_q <= snapshot[15:12]; end
            endcase
            if (state == IDLE) an_q <= AN_OFF;
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nib_q),
        .seg    (seg_dec)
    );

    // Blanking keys off the registered anodes so seg never disagrees with an.
    assign an  = an_q;
    assign seg = (an_q == AN_OFF) ? SEG_BLANK : seg_dec;

`ifdef DISP_DP_INDICATOR_EN
    logic dp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_q <= 1'b1;
        end else begin
            dp_q <= !((state != IDLE) && (sel == 2'd3) && cur_half);
        end
    end

    assign dp = dp_q;
`endif

endmodule
